// File: rtl/cpu_rom_fetch.sv
// CPU ROM fetch unit: one-entry 64-bit line buffer in front of SDRAM,
// returning the addressed 16-bit word to the CPU with a ready pulse.
module cpu_rom_fetch #(
    parameter logic [24:0] SDR_BASE = 25'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_strobe,
    input  logic        cpu_rom_memrq,
    input  logic [19:0] rom_addr,
    input  logic        flush,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        sdr_req,
    output logic [24:0] sdr_addr,
    input  logic        sdr_ack,
    input  logic [63:0] sdr_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        valid_q, valid_d;
    logic [16:0] tag_q, tag_d;
    logic [63:0] line_q, line_d;
    logic [19:0] addr_q, addr_d;
    logic        flush_seen_q, flush_seen_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        sdr_req_q, sdr_req_d;
    logic [24:0] sdr_addr_q, sdr_addr_d;

    logic        accept_s;
    logic        hit_s;

    function automatic logic [15:0] word_sel(input logic [63:0] line, input logic [1:0] sel);
        case (sel)
            2'd0:    word_sel = line[15:0];
            2'd1:    word_sel = line[31:16];
            2'd2:    word_sel = line[47:32];
            2'd3:    word_sel = line[63:48];
            default: word_sel = line[15:0];
        endcase
    endfunction

    assign accept_s = read_strobe & cpu_rom_memrq;
    // A flush coinciding with the strobe forces a miss.
    assign hit_s    = valid_q & (tag_q == rom_addr[19:3]) & ~flush;

    // Next-state and datapath logic for the fetch FSM.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        line_d       = line_q;
        addr_d       = addr_q;
        flush_seen_d = flush_seen_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_ready_d  = 1'b0;
        sdr_req_d    = sdr_req_q;
        sdr_addr_d   = sdr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
                if (accept_s) begin
                    addr_d = rom_addr;
                    if (hit_s) begin
                        state_d     = ST_RESP;
                        cpu_ready_d = 1'b1;
                        cpu_rdata_d = word_sel(line_q, rom_addr[2:1]);
                    end else begin
                        state_d      = ST_FETCH;
                        sdr_req_d    = 1'b1;
                        sdr_addr_d   = SDR_BASE + {5'b00000, rom_addr[19:3], 3'b000};
                        flush_seen_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (sdr_ack) begin
                    line_d      = sdr_data;
                    tag_d       = addr_q[19:3];
                    valid_d     = ~(flush_seen_q | flush);
                    sdr_req_d   = 1'b0;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = word_sel(sdr_data, addr_q[2:1]);
                    state_d     = ST_RESP;
                end else if (flush) begin
                    flush_seen_d = 1'b1;
                end else begin
                    flush_seen_d = flush_seen_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (flush) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                sdr_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            tag_q        <= 17'd0;
            line_q       <= 64'd0;
            addr_q       <= 20'd0;
            flush_seen_q <= 1'b0;
            cpu_rdata_q  <= 16'h0000;
            cpu_ready_q  <= 1'b0;
            sdr_req_q    <= 1'b0;
            sdr_addr_q   <= SDR_BASE;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            line_q       <= line_d;
            addr_q       <= addr_d;
            flush_seen_q <= flush_seen_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_ready_q  <= cpu_ready_d;
            sdr_req_q    <= sdr_req_d;
            sdr_addr_q   <= sdr_addr_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign sdr_req   = sdr_req_q;
    assign sdr_addr  = sdr_addr_q;

endmodule

// File: tb/tb_cpu_rom_fetch.sv
// Directed self-checking bench for cpu_rom_fetch; two instances differ only
// in SDR_BASE and share all stimulus.
module tb_cpu_rom_fetch;

    logic        clk;
    logic        reset;
    logic        read_strobe;
    logic        cpu_rom_memrq;
    logic [19:0] rom_addr;
    logic        flush;
    logic        sdr_ack;
    logic [63:0] sdr_data;
    logic [15:0] cpu_rdata0, cpu_rdata1;
    logic        cpu_ready0, cpu_ready1;
    logic        sdr_req0, sdr_req1;
    logic [24:0] sdr_addr0, sdr_addr1;

    int n_checks;
    int n_pass;

    cpu_rom_fetch #(.SDR_BASE(25'h000000)) u_dut0 (
        .clk(clk), .reset(reset), .read_strobe(read_strobe),
        .cpu_rom_memrq(cpu_rom_memrq), .rom_addr(rom_addr), .flush(flush),
        .cpu_rdata(cpu_rdata0), .cpu_ready(cpu_ready0), .sdr_req(sdr_req0),
        .sdr_addr(sdr_addr0), .sdr_ack(sdr_ack), .sdr_data(sdr_data)
    );

    cpu_rom_fetch #(.SDR_BASE(25'h100000)) u_dut1 (
        .clk(clk), .reset(reset), .read_strobe(read_strobe),
        .cpu_rom_memrq(cpu_rom_memrq), .rom_addr(rom_addr), .flush(flush),
        .cpu_rdata(cpu_rdata1), .cpu_ready(cpu_ready1), .sdr_req(sdr_req1),
        .sdr_addr(sdr_addr1), .sdr_ack(sdr_ack), .sdr_data(sdr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [19:0] a, input logic memrq);
        read_strobe   = 1'b1;
        cpu_rom_memrq = memrq;
        rom_addr      = a;
        tick();
        read_strobe   = 1'b0;
        cpu_rom_memrq = 1'b0;
    endtask

    task automatic ack(input logic [63:0] d);
        sdr_ack  = 1'b1;
        sdr_data = d;
        tick();
        sdr_ack  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        reset = 1'b1;
        read_strobe = 1'b0;
        cpu_rom_memrq = 1'b0;
        rom_addr = 20'h00000;
        flush = 1'b0;
        sdr_ack = 1'b0;
        sdr_data = 64'd0;
        tick();
        tick();
        reset = 1'b0;
        check_val("rst_ready", {63'd0, cpu_ready0}, 64'd0);
        check_val("rst_req", {63'd0, sdr_req0}, 64'd0);
        check_val("rst_rdata", {48'd0, cpu_rdata0}, 64'h0);
        check_val("rst_addr0", {39'd0, sdr_addr0}, 64'h0);
        check_val("rst_addr1", {39'd0, sdr_addr1}, 64'h100000);

        // First miss at 0x12, ack three cycles after the strobe.
        strobe(20'h00012, 1'b1);
        check_val("miss1_req", {63'd0, sdr_req0}, 64'd1);
        check_val("miss1_addr", {39'd0, sdr_addr0}, 64'h10);
        check_val("miss1_noready", {63'd0, cpu_ready0}, 64'd0);
        tick();
        tick();
        check_val("miss1_req_held", {63'd0, sdr_req0}, 64'd1);
        check_val("miss1_addr_held", {39'd0, sdr_addr0}, 64'h10);
        ack(64'h4444_3333_2222_1111);
        check_val("miss1_ready", {63'd0, cpu_ready0}, 64'd1);
        check_val("miss1_rdata", {48'd0, cpu_rdata0}, 64'h2222);
        check_val("miss1_req_low", {63'd0, sdr_req0}, 64'd0);
        tick();
        check_val("miss1_ready_pulse", {63'd0, cpu_ready0}, 64'd0);
        check_val("rdata_hold", {48'd0, cpu_rdata0}, 64'h2222);

        // Hit in the same line; rom_addr[0] is ignored.
        strobe(20'h00016, 1'b1);
        check_val("hit1_req", {63'd0, sdr_req0}, 64'd0);
        check_val("hit1_ready", {63'd0, cpu_ready0}, 64'd1);
        check_val("hit1_rdata", {48'd0, cpu_rdata0}, 64'h4444);
        tick();
        strobe(20'h00013, 1'b1);
        check_val("hit2_ready", {63'd0, cpu_ready0}, 64'd1);
        check_val("hit2_rdata", {48'd0, cpu_rdata0}, 64'h2222);
        tick();

        // Next line misses; minimum-latency ack.
        strobe(20'h00018, 1'b1);
        check_val("miss2_req", {63'd0, sdr_req0}, 64'd1);
        check_val("miss2_addr", {39'd0, sdr_addr0}, 64'h18);
        ack(64'hDDDD_CCCC_BBBB_AAAA);
        check_val("miss2_ready", {63'd0, cpu_ready0}, 64'd1);
        check_val("miss2_rdata", {48'd0, cpu_rdata0}, 64'hAAAA);
        tick();

        // High address, base offset, word 3, with a flush during FETCH.
        strobe(20'h8FFFE, 1'b1);
        check_val("miss3_addr0", {39'd0, sdr_addr0}, 64'h8FFF8);
        check_val("miss3_addr1", {39'd0, sdr_addr1}, 64'h18FFF8);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("miss3_req_flush", {63'd0, sdr_req0}, 64'd1);
        ack(64'h8888_7777_6666_5555);
        check_val("miss3_ready", {63'd0, cpu_ready0}, 64'd1);
        check_val("miss3_rdata", {48'd0, cpu_rdata0}, 64'h8888);
        check_val("miss3_rdata1", {48'd0, cpu_rdata1}, 64'h8888);
        tick();
        strobe(20'h8FFFE, 1'b1);
        check_val("refetch_req", {63'd0, sdr_req0}, 64'd1);
        check_val("refetch_noready", {63'd0, cpu_ready0}, 64'd0);
        ack(64'h8888_7777_6666_5555);
        check_val("refetch_ready", {63'd0, cpu_ready0}, 64'd1);
        tick();
        strobe(20'h8FFFC, 1'b1);
        check_val("hit3_req", {63'd0, sdr_req0}, 64'd0);
        check_val("hit3_rdata", {48'd0, cpu_rdata0}, 64'h7777);
        tick();

        // Non-ROM strobe plus stray ack in IDLE must do nothing.
        read_strobe = 1'b1;
        cpu_rom_memrq = 1'b0;
        rom_addr = 20'h00010;
        sdr_ack = 1'b1;
        sdr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        read_strobe = 1'b0;
        sdr_ack = 1'b0;
        check_val("nonrom_req", {63'd0, sdr_req0}, 64'd0);
        check_val("nonrom_ready", {63'd0, cpu_ready0}, 64'd0);
        tick();
        check_val("nonrom_ready2", {63'd0, cpu_ready0}, 64'd0);
        strobe(20'h8FFFA, 1'b1);
        check_val("stray_hit_req", {63'd0, sdr_req0}, 64'd0);
        check_val("stray_hit_ready", {63'd0, cpu_ready0}, 64'd1);
        check_val("stray_hit_rdata", {48'd0, cpu_rdata0}, 64'h6666);
        tick();

        // Flush with strobe in IDLE forces a miss; then reset inside FETCH.
        flush = 1'b1;
        strobe(20'h8FFFE, 1'b1);
        flush = 1'b0;
        check_val("flush_strobe_req", {63'd0, sdr_req0}, 64'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("fetch_rst_req", {63'd0, sdr_req0}, 64'd0);
        check_val("fetch_rst_ready", {63'd0, cpu_ready0}, 64'd0);
        ack(64'h1234_5678_9ABC_DEF0);
        check_val("late_ack_ready", {63'd0, cpu_ready0}, 64'd0);
        check_val("late_ack_req", {63'd0, sdr_req0}, 64'd0);
        tick();
        check_val("late_ack_ready2", {63'd0, cpu_ready0}, 64'd0);
        strobe(20'h8FFFE, 1'b1);
        check_val("post_rst_miss", {63'd0, sdr_req0}, 64'd1);
        ack(64'hAAAA_0000_0000_0000);
        check_val("post_rst_rdata", {48'd0, cpu_rdata0}, 64'hAAAA);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
